// File: rtl/voice_scheduler_pkg.sv
// music_pkg: shared definitions for the voice scheduler slice.
//   DEF_NOTE_W / DEF_DUR_W : default note code and duration widths
//   MAX_VOICES             : upper bound on voices any scheduler can manage
//   VIDX_W / voice_idx_t   : voice index type wide enough for MAX_VOICES
package music_pkg;

  localparam int DEF_NOTE_W = 6;
  localparam int DEF_DUR_W  = 6;
  localparam int MAX_VOICES = 8;
  localparam int VIDX_W     = $clog2(MAX_VOICES);

  typedef logic [VIDX_W-1:0] voice_idx_t;

endpackage

// File: rtl/voice_scheduler_if.sv
// voice_scheduler_if: request handshake from the song reader plus the shared
// note/duration load bus towards the note_player voices.
//   req_valid/req_note/req_duration : request from song reader
//   req_ready                       : request accepted when high with req_valid
//   load_note                       : one-hot load strobe, one cycle
//   note_out/duration_out           : shared load bus
//   voice_active                    : per-voice busy flags
// modport master: the requester side (song reader / testbench)
// modport slave : the scheduler
interface voice_scheduler_if #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = music_pkg::DEF_NOTE_W,
  parameter int DUR_W      = music_pkg::DEF_DUR_W
) ();

  logic                  req_valid;
  logic [NOTE_W-1:0]     req_note;
  logic [DUR_W-1:0]      req_duration;
  logic                  req_ready;
  logic [NUM_VOICES-1:0] load_note;
  logic [NOTE_W-1:0]     note_out;
  logic [DUR_W-1:0]      duration_out;
  logic [NUM_VOICES-1:0] voice_active;

  modport master (
    output req_valid, req_note, req_duration,
    input  req_ready, load_note, note_out, duration_out, voice_active
  );

  modport slave (
    input  req_valid, req_note, req_duration,
    output req_ready, load_note, note_out, duration_out, voice_active
  );

endinterface

// File: rtl/voice_scheduler_select.sv
// voice_select: combinational search over the per-voice remaining-beat counters.
//   remaining : remaining beats per voice (0 = free)
//   free_any  : at least one voice is free
//   free_idx  : lowest-index free voice (0 when none is free)
//   min_idx   : voice with the smallest remaining count, lowest index on a tie
module voice_select
  import music_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int DUR_W      = DEF_DUR_W
) (
  input  logic [NUM_VOICES-1:0][DUR_W-1:0] remaining,
  output logic                             free_any,
  output voice_idx_t                       free_idx,
  output voice_idx_t                       min_idx
);

  logic [DUR_W-1:0] min_val;

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    // Walk downwards so the last hit is the lowest free index.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (remaining[i] == '0) begin
        free_any = 1'b1;
        free_idx = voice_idx_t'(i);
      end
    end
  end

  always_comb begin
    min_idx = '0;
    min_val = remaining[0];
    // Strict less-than keeps the lowest index on ties.
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (remaining[i] < min_val) begin
        min_val = remaining[i];
        min_idx = voice_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// voice_scheduler: allocates note requests onto NUM_VOICES note_player voices
// sharing one note/duration load bus, tracking each voice's remaining beats.
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   play   : playback enable; low freezes scheduling and countdown
//   flush  : synchronous clear of all voices, cancels a pending strobe
//   beat   : one-cycle beat pulse
//   bus    : voice_scheduler_if.slave (request handshake + load bus)
// Optional build macro VOICE_STEAL_EN: when every voice is busy the request
// is still accepted and the voice with the smallest remaining count is reused.
module voice_scheduler
  import music_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int DUR_W      = DEF_DUR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play,
  input  logic                 flush,
  input  logic                 beat,
  voice_scheduler_if.slave     bus
);

  logic [NUM_VOICES-1:0][DUR_W-1:0] remaining;
  logic [NUM_VOICES-1:0][DUR_W-1:0] remaining_nxt;
  logic [NUM_VOICES-1:0]            load_q;
  logic [NUM_VOICES-1:0]            load_nxt;
  logic [NUM_VOICES-1:0]            active_q;
  logic [NUM_VOICES-1:0]            active_nxt;
  logic [NOTE_W-1:0]                note_q;
  logic [DUR_W-1:0]                 dur_q;

  logic       free_any;
  voice_idx_t free_idx;
  voice_idx_t min_idx;
  voice_idx_t target;
  logic       sched_ok;
  logic       ready;
  logic       accept;
  logic       do_load;

  voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .DUR_W      (DUR_W)
  ) u_select (
    .remaining (remaining),
    .free_any  (free_any),
    .free_idx  (free_idx),
    .min_idx   (min_idx)
  );

  assign sched_ok = play & ~flush;

`ifdef VOICE_STEAL_EN
  assign ready  = sched_ok;
  assign target = free_any ? free_idx : min_idx;
`else
  logic unused_min_idx;
  assign unused_min_idx = ^min_idx;
  assign ready  = sched_ok & free_any;
  assign target = free_idx;
`endif

  assign accept  = bus.req_valid & ready;
  // A zero-duration request is a rest: consumed without touching any voice.
  assign do_load = accept & (bus.req_duration != '0);

  always_comb begin
    remaining_nxt = remaining;
    load_nxt      = '0;
    if (flush) begin
      remaining_nxt = '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (do_load && target == voice_idx_t'(i)) begin
          remaining_nxt[i] = bus.req_duration;
          load_nxt[i]      = 1'b1;
        end else if (play && beat && remaining[i] != '0) begin
          remaining_nxt[i] = remaining[i] - DUR_W'(1);
        end
      end
    end
  end

  always_comb begin
    active_nxt = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      active_nxt[i] = (remaining_nxt[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= '0;
      load_q    <= '0;
      active_q  <= '0;
      note_q    <= '0;
      dur_q     <= '0;
    end else begin
      remaining <= remaining_nxt;
      load_q    <= load_nxt;
      active_q  <= active_nxt;
      if (do_load) begin
        note_q <= bus.req_note;
        dur_q  <= bus.req_duration;
      end
    end
  end

  assign bus.req_ready    = ready;
  // flush during the strobe cycle suppresses the strobe already in flight.
  assign bus.load_note    = load_q & {NUM_VOICES{~flush}};
  assign bus.note_out     = note_q;
  assign bus.duration_out = dur_q;
  assign bus.voice_active = active_q;

endmodule

// File: tb/tb_voice_scheduler.sv
module tb_voice_scheduler;

  localparam int NV = 3;
  localparam int NW = 6;
  localparam int DW = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic play = 1'b0;
  logic flush = 1'b0;
  logic beat = 1'b0;

  int checks = 0;
  int errors = 0;

  voice_scheduler_if #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) bus ();

  voice_scheduler #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .play  (play),
    .flush (flush),
    .beat  (beat),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: remaining beats per voice as plain integers,
  // the strobe mask due in the current cycle, and the last loaded request.
  int rem[NV];
  int pend;
  int m_note;
  int m_dur;

  function automatic bit m_ready();
    bit any = 1'b0;
    for (int i = 0; i < NV; i++) if (rem[i] == 0) any = 1'b1;
`ifdef VOICE_STEAL_EN
    any = 1'b1;
`endif
    return play && !flush && any;
  endfunction

  function automatic int m_target();
    int best = 0;
    for (int i = 0; i < NV; i++) if (rem[i] == 0) return i;
    for (int i = 1; i < NV; i++) if (rem[i] < rem[best]) best = i;
    return best;
  endfunction

  function automatic logic [NV-1:0] exp_active();
    logic [NV-1:0] a = '0;
    for (int i = 0; i < NV; i++) a[i] = (rem[i] != 0);
    return a;
  endfunction

  function automatic logic [NV-1:0] exp_load();
    logic [NV-1:0] p = NV'(pend);
    return flush ? '0 : p;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NV; i++) rem[i] = 0;
    pend = 0; m_note = 0; m_dur = 0;
  endtask

  // Advance one clock; the model consumes the inputs present before the edge.
  task automatic tick();
    bit acc;
    int t, d, n;
    bit f, p, b;
    int nrem[NV];
    acc = bus.req_valid && m_ready();
    t = m_target();
    d = int'(bus.req_duration);
    n = int'(bus.req_note);
    f = flush; p = play; b = beat;
    @(posedge clk);
    #1;
    if (f) begin
      for (int i = 0; i < NV; i++) rem[i] = 0;
      pend = 0;
    end else begin
      for (int i = 0; i < NV; i++) begin
        nrem[i] = rem[i];
        if (acc && d != 0 && i == t) nrem[i] = d;
        else if (p && b && rem[i] > 0) nrem[i] = rem[i] - 1;
      end
      pend = 0;
      if (acc && d != 0) begin
        pend = 1 << t; m_note = n; m_dur = d;
      end
      for (int i = 0; i < NV; i++) rem[i] = nrem[i];
    end
  endtask

  task automatic set_req(input bit v, input int n, input int d);
    bus.req_valid    = v;
    bus.req_note     = NW'(n);
    bus.req_duration = DW'(d);
  endtask

  task automatic test_reset();
    set_req(0, 0, 0);
    play = 0; flush = 0; beat = 0;
    reset = 1'b1;
    model_clear();
    #23;
    checks++;
    if (bus.load_note !== 3'b000) begin errors++; $display("FAIL reset_load got %b want 000", bus.load_note); end
    checks++;
    if (bus.note_out !== 6'd0 || bus.duration_out !== 6'd0) begin
      errors++; $display("FAIL reset_bus got note %0d dur %0d want 0 0", bus.note_out, bus.duration_out);
    end
    checks++;
    if (bus.voice_active !== 3'b000) begin errors++; $display("FAIL reset_active got %b want 000", bus.voice_active); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_accept();
    play = 1;
    set_req(1, 12, 4);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", bus.req_ready); end
    tick();
    set_req(0, 0, 0);
    checks++;
    if (bus.load_note !== 3'b001 || bus.note_out !== 6'd12 || bus.duration_out !== 6'd4) begin
      errors++; $display("FAIL single_strobe got %b/%0d/%0d want 001/12/4", bus.load_note, bus.note_out, bus.duration_out);
    end
    tick();
    checks++;
    if (bus.load_note !== 3'b000) begin errors++; $display("FAIL single_once got %b want 000", bus.load_note); end
    for (int k = 1; k <= 4; k++) begin
      beat = 1; tick(); beat = 0;
      checks++;
      if (bus.voice_active !== ((k < 4) ? 3'b001 : 3'b000)) begin
        errors++; $display("FAIL single_beat%0d active got %b want %b", k, bus.voice_active, (k < 4) ? 3'b001 : 3'b000);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [NV-1:0] want[3];
    want[0] = 3'b001; want[1] = 3'b010; want[2] = 3'b100;
    for (int k = 0; k < 3; k++) begin
      set_req(1, 20 + k, 10 + k);
      tick();
      checks++;
      if (bus.load_note !== want[k] || bus.duration_out !== DW'(10 + k)) begin
        errors++; $display("FAIL b2b_%0d got %b dur %0d want %b dur %0d", k, bus.load_note, bus.duration_out, want[k], 10 + k);
      end
    end
    set_req(1, 30, 9);
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b want 0", bus.req_ready); end
    tick();
    set_req(0, 0, 0);
    checks++;
    if (bus.load_note !== 3'b000 || bus.voice_active !== 3'b111) begin
      errors++; $display("FAIL b2b_full got load %b active %b want 000 111", bus.load_note, bus.voice_active);
    end
  endtask

  task automatic test_free_on_beat();
    // voices hold 10,11,12; nine beats leave voice 0 at 1
    beat = 1;
    for (int k = 0; k < 9; k++) tick();
    set_req(1, 7, 5);
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL fob_beatcycle_ready got %b want 0", bus.req_ready); end
    tick();
    beat = 0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL fob_next_ready got %b want 1", bus.req_ready); end
    tick();
    set_req(0, 0, 0);
    checks++;
    if (bus.load_note !== 3'b001 || bus.note_out !== 6'd7 || bus.voice_active !== 3'b111) begin
      errors++; $display("FAIL fob_strobe got %b note %0d active %b want 001 7 111", bus.load_note, bus.note_out, bus.voice_active);
    end
  endtask

  task automatic test_rest_freeze();
    flush = 1; tick(); flush = 0;
    set_req(1, 3, 0);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rest_ready got %b want 1", bus.req_ready); end
    tick();
    set_req(0, 0, 0);
    checks++;
    if (bus.load_note !== 3'b000 || bus.voice_active !== 3'b000) begin
      errors++; $display("FAIL rest_nostrobe got %b active %b want 000 000", bus.load_note, bus.voice_active);
    end
    set_req(1, 9, 3); tick(); set_req(0, 0, 0);
    play = 0;
    #1;
    checks++;
    if (bus.load_note !== 3'b001) begin errors++; $display("FAIL freeze_strobe_survives got %b want 001", bus.load_note); end
    set_req(1, 5, 5);
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL freeze_ready got %b want 0", bus.req_ready); end
    beat = 1;
    for (int k = 0; k < 3; k++) tick();
    set_req(0, 0, 0);
    play = 1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (bus.voice_active !== ((k < 3) ? 3'b001 : 3'b000)) begin
        errors++; $display("FAIL freeze_hold%0d active got %b want %b", k, bus.voice_active, (k < 3) ? 3'b001 : 3'b000);
      end
    end
    beat = 0;
  endtask

  task automatic test_flush();
    set_req(1, 40, 7); tick(); set_req(0, 0, 0);
    flush = 1;
    #1;
    checks++;
    if (bus.load_note !== 3'b000) begin errors++; $display("FAIL flush_cancel got %b want 000", bus.load_note); end
    tick();
    flush = 0;
    #1;
    checks++;
    if (bus.voice_active !== 3'b000) begin errors++; $display("FAIL flush_active got %b want 000", bus.voice_active); end
  endtask

`ifdef VOICE_STEAL_EN
  task automatic test_steal();
    flush = 1; tick(); flush = 0;
    set_req(1, 1, 5); tick();
    set_req(1, 2, 2); tick();
    set_req(1, 3, 2); tick();
    set_req(1, 4, 9);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL steal_ready got %b want 1", bus.req_ready); end
    tick();
    set_req(0, 0, 0);
    checks++;
    if (bus.load_note !== 3'b010 || bus.duration_out !== 6'd9 || rem[1] != 9) begin
      errors++; $display("FAIL steal_victim got %b dur %0d want 010 9", bus.load_note, bus.duration_out);
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      play  = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 39) == 0);
      beat  = ($urandom_range(0, 3) == 0);
      set_req($urandom_range(0, 1) == 1, int'($urandom_range(0, 63)),
              ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12)));
      #1;
      checks++;
      if (bus.req_ready !== m_ready()) begin
        errors++; $display("FAIL rand_ready c%0d got %b want %b", c, bus.req_ready, m_ready());
      end
      checks++;
      if (bus.load_note !== exp_load()) begin
        errors++; $display("FAIL rand_load c%0d got %b want %b", c, bus.load_note, exp_load());
      end
      checks++;
      if (bus.voice_active !== exp_active()) begin
        errors++; $display("FAIL rand_active c%0d got %b want %b", c, bus.voice_active, exp_active());
      end
      checks++;
      if (bus.note_out !== NW'(m_note) || bus.duration_out !== DW'(m_dur)) begin
        errors++; $display("FAIL rand_bus c%0d got %0d/%0d want %0d/%0d", c, bus.note_out, bus.duration_out, m_note, m_dur);
      end
      tick();
    end
    flush = 0; beat = 0; play = 1;
    set_req(0, 0, 0);
  endtask

  task automatic test_reset_mid();
    flush = 1; tick(); flush = 0;
    set_req(1, 33, 6); tick(); set_req(0, 0, 0);
    checks++;
    if (bus.load_note !== 3'b001) begin errors++; $display("FAIL midrst_pre got %b want 001", bus.load_note); end
    reset = 1;
    model_clear();
    #1;
    checks++;
    if (bus.load_note !== 3'b000 || bus.voice_active !== 3'b000 || bus.note_out !== 6'd0) begin
      errors++; $display("FAIL midrst_clear got %b active %b note %0d want 000 000 0", bus.load_note, bus.voice_active, bus.note_out);
    end
    #1;
    reset = 0;
    tick();
    checks++;
    if (bus.voice_active !== 3'b000 || bus.load_note !== 3'b000) begin
      errors++; $display("FAIL midrst_after got active %b load %b want 000 000", bus.voice_active, bus.load_note);
    end
  endtask

  initial begin
    test_reset();
    test_single_accept();
    test_back_to_back();
    test_free_on_beat();
    test_rest_freeze();
    test_flush();
`ifdef VOICE_STEAL_EN
    test_steal();
`endif
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
Allocates note requests from the song reader onto a pool of NUM_VOICES note_player voices that share one note/duration load bus.
- Tracks each voice's remaining beats internally.
- Issues a one-hot load strobe to the chosen voice.
- Applies valid/ready back-pressure when no voice is free.
- Sits between song_reader and the note_player array in music_player; the mixer is unchanged.

Parameters:
- NUM_VOICES, 3, number of note_player voices managed (1..8)
- NOTE_W, 6, note code width
- DUR_W, 6, duration width in beats

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- play  input  1  playback enable from mcu; low freezes scheduling and countdown
- flush  input  1  synchronous clear (driven by reset_player); frees all voices
- beat  input  1  one-cycle beat pulse from beat_generator
- req_valid  input  1  note request valid
- req_note  input  NOTE_W  requested note
- req_duration  input  DUR_W  requested duration in beats
- req_ready  output  1  request accepted this cycle when high with req_valid
- load_note  output  NUM_VOICES  one-hot load strobe, one cycle
- note_out  output  NOTE_W  shared note bus to voices
- duration_out  output  DUR_W  shared duration bus to voices
- voice_active  output  NUM_VOICES  bit i high while voice i remaining > 0

Behaviour:
- Reset (async, active-high):
  - load_note=0, note_out=0, duration_out=0, voice_active=0.
  - All remaining counters = 0.
- State per voice: remaining[i], DUR_W bits. Voice free ⇔ remaining[i]==0.
- req_ready is combinational: play & ~flush & (any voice free), or (play & ~flush) alone when VOICE_STEAL_EN is defined.
- Accept = req_valid & req_ready, at edge N:
  - The target voice is the lowest-index free voice.
  - remaining[target] <= req_duration.
  - In cycle N+1: load_note[target]=1, with note_out and duration_out holding the registered request.
  - Latency is exactly 1 cycle from accept to strobe. load_note is otherwise 0.
  - Back-to-back accepts are allowed. Allocation uses post-update state, so consecutive requests go to distinct voices.
- req_duration==0: accepted and discarded. No strobe, no counter change (rest).
- Beat with play=1: every remaining[i]>0 that is not the accept target in the same cycle decrements by 1. The accept target loads req_duration undecremented.
- Free-status rule: a voice whose remaining is 1 when a beat arrives is free from the next cycle onward. Allocation in the beat cycle uses the pre-beat state.
- play=0:
  - req_ready=0.
  - Counters hold and beats are ignored.
  - A strobe already scheduled for N+1 still issues.
- flush=1:
  - All remaining <= 0 and req_ready=0.
  - A pending strobe is cancelled (load_note=0 next cycle).
  - flush takes priority over beat and accept.
- Reset mid-operation clears everything immediately; no strobe survives.
- voice_active is registered and equals (remaining != 0) per voice.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- Defined: when no voice is free, the request is still accepted.
  - The victim is the voice with the smallest remaining; ties go to the lowest index.
  - The victim is reloaded, and the strobe timing is as for a normal accept.
- Undefined: req_ready stays low while all voices are busy; the request waits for a free voice.

Decomposition:
- Shared package music_pkg: NOTE_W/DUR_W defaults and the MAX_VOICES=8 constant.
- One sub-module, voice_select (combinational). Inputs: remaining array. Outputs:
  - free_any and free_idx (lowest free voice);
  - min_idx (smallest remaining, lowest index on tie).
- Counters and output registers live in voice_scheduler.

Test Plan:
- Reset and single accept: reset, then play=1 and req (note 12, dur 4) → load_note=001 next cycle, note_out=12, duration_out=4; voice_active[0] clears on the 4th beat.
- Back-to-back: three requests on consecutive cycles → strobes 001, 010, 100 on consecutive cycles; req_ready=0 on a fourth request (steal undefined).
- Free on beat: voice 0 has remaining 1, all voices busy; beat, then request in the next cycle → accepted, load_note=001. A request in the beat cycle itself is not accepted.
- Rest and freeze: req dur=0 → req_ready=1, no strobe. play=0 with 3 beats → counters unchanged, req_ready=0.
- Flush: flush asserted in the cycle after an accept → strobe cancelled, voice_active=000 the next cycle.
- Steal (VOICE_STEAL_EN): remaining {5,2,2}, new request → load_note=010, remaining[1]=new duration.
